// File: rtl/seq_arith_unit.sv
// Clocked unsigned add/sub/multiply/divide unit with a start/busy/done handshake.
// Add, sub and divide-by-zero finish in 1 cycle; multiply and divide take WIDTH+1 cycles.
module seq_arith_unit #(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic [2*WIDTH-1:0] result,
    output logic               flag,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q,  state_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   acc_q,    acc_d;
    logic [WIDTH-1:0]   mq_q,     mq_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               flag_q,   flag_d;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     mul_add;
    logic [WIDTH-1:0]   mul_hi_n;
    logic [WIDTH-1:0]   mul_lo_n;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   rem_n;
    logic [WIDTH-1:0]   quo_n;

    // acc holds the product high half (mul) or the partial remainder (div);
    // mq holds the multiplier/product low half or the dividend/quotient.
    always_comb begin
        add_sub_defaults: begin
            add_sum  = {1'b0, x} + {1'b0, y};
            sub_diff = {1'b0, x} - {1'b0, y};
        end

        mul_sum  = {1'b0, acc_q} + {1'b0, a_q};
        mul_add  = mq_q[0] ? mul_sum : {1'b0, acc_q};
        mul_hi_n = mul_add[WIDTH:1];
        mul_lo_n = {mul_add[0], mq_q[WIDTH-1:1]};

        div_trial = {acc_q, mq_q[WIDTH-1]};
        div_ge    = (div_trial >= {1'b0, a_q});
        div_diff  = div_trial[WIDTH-1:0] - a_q;
        rem_n     = div_ge ? div_diff : div_trial[WIDTH-1:0];
        quo_n     = {mq_q[WIDTH-2:0], div_ge};

        state_d  = state_q;
        is_div_d = is_div_q;
        a_d      = a_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flag_d   = flag_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d = op[0];
                    a_d      = y;
                    acc_d    = '0;
                    mq_d     = x;
                    cnt_d    = '0;
                    case (op)
                        2'b00: begin
                            result_d = {{(WIDTH-1){1'b0}}, add_sum};
                            flag_d   = add_sum[WIDTH];
                            state_d  = DONE;
                        end
                        2'b01: begin
                            result_d = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
                            flag_d   = (x < y);
                            state_d  = DONE;
                        end
                        2'b10: state_d = CALC;
                        default: begin
                            if (y == '0) begin
                                result_d = {x, {WIDTH{1'b1}}};
                                flag_d   = 1'b1;
                                state_d  = DONE;
                            end else begin
                                state_d = CALC;
                            end
                        end
                    endcase
                end
            end
            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div_q) begin
                    acc_d = rem_n;
                    mq_d  = quo_n;
                end else begin
                    acc_d = mul_hi_n;
                    mq_d  = mul_lo_n;
                end
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    if (is_div_q) begin
                        result_d = {rem_n, quo_n};
                        flag_d   = 1'b0;
                    end else begin
                        result_d = {mul_hi_n, mul_lo_n};
                        flag_d   = |mul_hi_n;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            a_q      <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

    assign result = result_q;
    assign flag   = flag_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

endmodule
